sram_row_loader: RTL and testbench

Upstream fill stage for the `sram_array` weight/Q-table banks. It accepts a narrow stream of `DATA_WIDTH`-bit words over a valid/ready handshake and packs `COUNT` consecutive words into one full-width row. It then issues a single-cycle write of that row to a consecutive row address. It loads `num_rows` rows starting at `base_addr`, pulses `done`, and drives the array's `addr`/`mem_data_in`/`mem_en`/`mem_write_en` ports directly.

---
 rtl/sram_row_loader.sv | 121 ++++++++++++
 tb/tb_sram_row_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_row_loader.sv
// sram_row_loader: packs COUNT stream words into one row and writes
// num_rows consecutive rows (wrapping at HEIGHT) into the sram_array banks.
module sram_row_loader #(
    parameter int COUNT      = 128,
    parameter int DATA_WIDTH = 16,
    parameter int HEIGHT     = 128,
    parameter int ADDR_BITS  = 7
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        start,
    input  logic [ADDR_BITS-1:0]        base_addr,
    input  logic [ADDR_BITS:0]          num_rows,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [ADDR_BITS-1:0]        addr,
    output logic [DATA_WIDTH*COUNT-1:0] mem_data_in,
    output logic                        mem_en,
    output logic                        mem_write_en,
    output logic                        busy,
    output logic                        done
);

    localparam int LANE_BITS = (COUNT > 1) ? $clog2(COUNT) : 1;

    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(COUNT - 1);
    localparam logic [LANE_BITS-1:0] LANE_ONE  = LANE_BITS'(1);
    localparam logic [ADDR_BITS-1:0] LAST_ROW  = ADDR_BITS'(HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] ROW_ONE   = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                      state;
    state_t                      state_next;
    logic [DATA_WIDTH*COUNT-1:0] row_buf;
    logic [ADDR_BITS-1:0]        row_addr;
    logic [ADDR_BITS:0]          rows_left;
    logic [LANE_BITS-1:0]        lane_idx;
    logic                        accept;

    assign accept = (state == FILL) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_rows == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (accept && (lane_idx == LAST_LANE)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (rows_left == CNT_ONE) ? DONE : FILL;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode, driven from the state register only
    always_comb begin
        in_ready     = (state == FILL);
        mem_en       = (state == WRITE);
        mem_write_en = (state == WRITE);
        busy         = (state != IDLE);
        done         = (state == DONE);
    end

    // Datapath: load parameters, pack lanes, step address and row count
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            row_buf   <= '0;
            row_addr  <= '0;
            rows_left <= '0;
            lane_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_addr  <= base_addr;
                        rows_left <= num_rows;
                        lane_idx  <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        row_buf[lane_idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        lane_idx <= (lane_idx == LAST_LANE) ? '0 : lane_idx + LANE_ONE;
                    end
                end
                WRITE: begin
                    rows_left <= rows_left - CNT_ONE;
                    row_addr  <= (row_addr == LAST_ROW) ? '0 : row_addr + ROW_ONE;
                end
                default: ;
            endcase
        end
    end

    assign addr        = row_addr;
    assign mem_data_in = row_buf;

endmodule

// File: tb/tb_sram_row_loader.sv
// Randomized bench for sram_row_loader against a row-level reference model.
module tb_sram_row_loader;

    localparam int COUNT  = 4;
    localparam int DW     = 16;
    localparam int HEIGHT = 8;
    localparam int AB     = 3;
    localparam int RW     = DW * COUNT;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic [AB:0]   num_rows = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AB-1:0] addr;
    logic [RW-1:0] mem_data_in;
    logic          mem_en;
    logic          mem_write_en;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] first_row;
    int            first_addr;

    sram_row_loader #(
        .COUNT      (COUNT),
        .DATA_WIDTH (DW),
        .HEIGHT     (HEIGHT),
        .ADDR_BITS  (AB)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .addr         (addr),
        .mem_data_in  (mem_data_in),
        .mem_en       (mem_en),
        .mem_write_en (mem_write_en),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_addr"}, 64'(addr), 64'd0);
        check({tag, "_data"}, 64'(mem_data_in), 64'd0);
        check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_write_en), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // One complete load: drive the stream, record every write, compare with
    // rows computed directly from the word list and the address rule.
    task automatic run_load(input int base, input int n, input int stall_pct,
                            input bit seq_words, input bit mid_start, input string tag);
        logic [DW-1:0] words[$];
        logic [RW-1:0] gdata[$];
        int            gaddr[$];
        logic [RW-1:0] row;
        int wi = 0;
        int cyc = 0;
        int done_cyc = -1;
        int budget;
        for (int i = 0; i < n * COUNT; i++)
            words.push_back(seq_words ? DW'(i + 1) : DW'($urandom));
        budget = 50 + n * COUNT * 10;

        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_done"}, 64'(done), 64'd0);
        start = 1'b1;
        base_addr = AB'(base);
        num_rows = (AB + 1)'(n);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_entry"}, 64'(busy), 64'd1);
        if (n > 0) check({tag, "_ready_entry"}, 64'(in_ready), 64'd1);

        while (cyc < budget) begin
            if (mem_write_en) begin
                gaddr.push_back(int'(addr));
                gdata.push_back(mem_data_in);
                check({tag, "_wr_ready"}, 64'(in_ready), 64'd0);
                check({tag, "_wr_en"}, 64'(mem_en), 64'd1);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            in_valid = (wi < words.size()) && ($urandom_range(99) >= stall_pct);
            in_data = in_valid ? words[wi] : DW'($urandom);
            if (in_valid && in_ready) wi++;
            if (mid_start && cyc == 2) begin
                start = 1'b1;
                base_addr = AB'(base + 3);
                num_rows = (AB + 1)'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;

        check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        if (stall_pct == 0)
            check({tag, "_done_cycle"}, 64'(done_cyc), 64'(n * (COUNT + 1)));
        check({tag, "_nwrites"}, 64'(gaddr.size()), 64'(n));
        check({tag, "_words_used"}, 64'(wi), 64'(words.size()));
        for (int r = 0; r < n && r < gaddr.size(); r++) begin
            row = '0;
            for (int l = COUNT - 1; l >= 0; l--)
                row = (row << DW) | RW'(words[r * COUNT + l]);
            check({tag, "_addr"}, 64'(gaddr[r]), 64'((base + r) % HEIGHT));
            check({tag, "_row"}, 64'(gdata[r]), 64'(row));
        end
        if (gaddr.size() > 0) begin
            first_row = gdata[0];
            first_addr = gaddr[0];
        end
    endtask

    initial begin
        // Reset state
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_b = 1'b1;

        // Basic load with fixed words 1..8
        run_load(2, 2, 0, 1'b1, 1'b0, "basic");
        check("basic_row0_const", 64'(first_row), 64'h0004_0003_0002_0001);
        check("basic_addr0_const", 64'(first_addr), 64'd2);

        // Wrap-around
        run_load(7, 3, 0, 1'b0, 1'b0, "wrap");

        // Stalls with same packing as basic
        run_load(2, 2, 50, 1'b1, 1'b0, "stall");
        check("stall_row0_const", 64'(first_row), 64'h0004_0003_0002_0001);

        // Zero rows
        run_load(3, 0, 0, 1'b0, 1'b0, "zero");

        // Start mid-FILL is ignored
        run_load(4, 2, 0, 1'b0, 1'b1, "midstart");

        // Reset after 2 of 4 words
        @(negedge clk);
        start = 1'b1;
        base_addr = AB'(5);
        num_rows = (AB + 1)'(2);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 16'hAAAA;
        @(negedge clk);
        in_data = 16'hBBBB;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_ready", 64'(in_ready), 64'd1);
        rst_b = 1'b0;
        #1;
        check_all_zero("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_we", 64'(mem_write_en), 64'd0);
        end
        rst_b = 1'b1;
        run_load(1, 1, 0, 1'b0, 1'b0, "after_rst");

        // Full depth
        run_load(0, 8, 0, 1'b0, 1'b0, "full");

        // Random loads with stalls
        for (int k = 0; k < 4; k++)
            run_load(int'($urandom_range(HEIGHT - 1)), int'($urandom_range(3, 1)), 50,
                     1'b0, 1'b0, "rand");

        @(negedge clk);
        check("final_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
